// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore sequence generator: direction encoding
// and the wrapping next-index helpers used by the state update.
package moore_seq_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Next state index in a ring of num entries, stepping by +1 or -1.
  function automatic int unsigned next_index(input int unsigned idx,
                                             input int unsigned num,
                                             input dir_e        d);
    int unsigned nxt;
    if (d == DIR_UP) begin
      nxt = (idx == num - 1) ? 0 : idx + 1;
    end else begin
      nxt = (idx == 0) ? num - 1 : idx - 1;
    end
    return nxt;
  endfunction

  // True when stepping from idx in direction d crosses the ring boundary.
  function automatic logic is_wrap(input int unsigned idx,
                                   input int unsigned num,
                                   input dir_e        d);
    logic w;
    if (d == DIR_UP) begin
      w = (idx == num - 1);
    end else begin
      w = (idx == 0);
    end
    return w;
  endfunction

endpackage

// File: rtl/moore_seq_dwell.sv
// Dwell counter for moore_seq_gen: holds each state for dwell_cfg extra
// enabled cycles and flags when the sequence may advance.
module moore_seq_dwell
  import moore_seq_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell_cfg,
  output logic               adv_ok
);

  logic [DWELL_W-1:0] count;

  assign adv_ok = en && (count == dwell_cfg);

  // Restart the dwell on any state change (advance or jump).
  always_ff @(posedge clk) begin
    if (reset || load || adv_ok) begin
      count <= '0;
    end else if (en) begin
      count <= count + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/moore_seq_gen.sv
// Programmable Moore sequence generator: a ring of NUM_STATES states, each
// driving a writable output pattern. Define MOORE_SEQ_DWELL_EN for dwell mode.
module moore_seq_gen
  import moore_seq_pkg::*;
#(
  parameter  int unsigned NUM_STATES = 4,
  parameter  int unsigned OUT_W      = 8,
  parameter  int unsigned DWELL_W    = 4,
  localparam int unsigned SW         = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [SW-1:0]      load_state,
  input  logic               pat_we,
  input  logic [SW-1:0]      pat_addr,
  input  logic [OUT_W-1:0]   pat_data,
  input  logic [DWELL_W-1:0] dwell_cfg,
  output logic [OUT_W-1:0]   out,
  output logic [SW-1:0]      state,
  output logic               wrap
);

  if (NUM_STATES < 2 || NUM_STATES > 256) begin : g_bad_num_states
    $error("moore_seq_gen: NUM_STATES must be in 2..256");
  end

  // One extra bit so the index range check also works for power-of-two sizes.
  localparam logic [SW:0] NS_EXT = (SW + 1)'(NUM_STATES);

  logic [OUT_W-1:0] pat [NUM_STATES];
  logic [SW-1:0]    state_nxt;
  logic             wrap_nxt;
  logic             adv;
  logic             load_ok;
  logic             addr_ok;

  assign load_ok = ({1'b0, load_state} < NS_EXT);
  assign addr_ok = ({1'b0, pat_addr} < NS_EXT);

`ifdef MOORE_SEQ_DWELL_EN
  moore_seq_dwell #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .load     (load),
    .dwell_cfg(dwell_cfg),
    .adv_ok   (adv)
  );
`else
  logic unused_dwell_cfg;
  assign unused_dwell_cfg = ^dwell_cfg;
  assign adv = en;
`endif

  // Jump beats advance; wrap only pulses on a real boundary crossing.
  always_comb begin
    state_nxt = state;
    wrap_nxt  = 1'b0;
    if (load) begin
      state_nxt = load_ok ? load_state : '0;
    end else if (adv) begin
      state_nxt = SW'(next_index(32'(state), NUM_STATES, dir_e'(dir)));
      wrap_nxt  = is_wrap(32'(state), NUM_STATES, dir_e'(dir));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      wrap  <= 1'b0;
      for (int i = 0; i < int'(NUM_STATES); i++) begin
        pat[i] <= OUT_W'(i);
      end
    end else begin
      state <= state_nxt;
      wrap  <= wrap_nxt;
      if (pat_we && addr_ok) begin
        pat[pat_addr] <= pat_data;
      end
    end
  end

  // Output is a pure function of registered state and table contents.
  assign out = pat[state];

endmodule

// File: tb/tb_moore_seq_gen.sv
// Self-checking bench for moore_seq_gen: directed scenarios plus random
// stimulus compared against a ring-arithmetic reference model.
module tb_moore_seq_gen;
  import moore_seq_pkg::*;

  localparam int N  = 5;
  localparam int OW = 8;
  localparam int DW = 4;
  localparam int SW = $clog2(N);
`ifdef MOORE_SEQ_DWELL_EN
  localparam bit DWELL_MODE = 1'b1;
`else
  localparam bit DWELL_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          dir = 1'b0;
  logic          load = 1'b0;
  logic [SW-1:0] load_state = '0;
  logic          pat_we = 1'b0;
  logic [SW-1:0] pat_addr = '0;
  logic [OW-1:0] pat_data = '0;
  logic [DW-1:0] dwell_cfg = '0;
  logic [OW-1:0] out;
  logic [SW-1:0] state;
  logic          wrap;

  always #5 clk = ~clk;

  moore_seq_gen #(
    .NUM_STATES(N),
    .OUT_W     (OW),
    .DWELL_W   (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .dir       (dir),
    .load      (load),
    .load_state(load_state),
    .pat_we    (pat_we),
    .pat_addr  (pat_addr),
    .pat_data  (pat_data),
    .dwell_cfg (dwell_cfg),
    .out       (out),
    .state     (state),
    .wrap      (wrap)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int m_state;
  int m_wrap;
  int m_count;
  int m_pat [N];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic model_step();
    int  nxt;
    int  w;
    int  c;
    bit  go;
    if (reset) begin
      m_state = 0;
      m_wrap  = 0;
      m_count = 0;
      for (int i = 0; i < N; i++) m_pat[i] = i % 256;
      return;
    end
    nxt = m_state;
    w   = 0;
    c   = m_count;
    if (load) begin
      nxt = (int'(load_state) < N) ? int'(load_state) : 0;
      c   = 0;
    end else begin
      go = en && (!DWELL_MODE || m_count == int'(dwell_cfg));
      if (go) begin
        nxt = dir ? (m_state + N - 1) % N : (m_state + 1) % N;
        w   = dir ? int'(nxt > m_state) : int'(nxt < m_state);
        c   = 0;
      end else if (en) begin
        c = (m_count + 1) % (1 << DW);
      end
    end
    if (pat_we && int'(pat_addr) < N) m_pat[pat_addr] = int'(pat_data);
    m_state = nxt;
    m_wrap  = w;
    m_count = c;
  endtask

  task automatic step(input logic r, input logic e, input logic d, input logic l,
                      input int ls, input logic we, input int pa, input int pd,
                      input int cfg, input string tag);
    @(negedge clk);
    reset      = r;
    en         = e;
    dir        = d;
    load       = l;
    load_state = SW'(ls);
    pat_we     = we;
    pat_addr   = SW'(pa);
    pat_data   = OW'(pd);
    dwell_cfg  = DW'(cfg);
    model_step();
    @(posedge clk);
    #1;
    check_val({tag, ".state"}, 32'(state), 32'(m_state));
    check_val({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    check_val({tag, ".out"},   32'(out),   32'(m_pat[m_state] % 256));
  endtask

  initial begin
    int up_exp [5];
    int dn_exp [4];
    up_exp = '{1, 2, 3, 4, 0};
    dn_exp = '{4, 3, 2, 1};

    // Reset overrides load, en and pat_we
    step(1, 1, 0, 1, 3, 1, 2, 8'hFF, 0, "rst");
    check_val("rst_state0", 32'(state), 32'd0);
    check_val("rst_out0",   32'(out),   32'd0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0, 0, 0, 0, 0, 0, "up");
      check_val("up_seq",  32'(state), 32'(up_exp[i]));
      check_val("up_wrap", 32'(wrap),  32'(i == 4));
    end

    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 0, 0, 0, 0, 0, "down");
      check_val("dn_seq",  32'(state), 32'(dn_exp[i]));
      check_val("dn_wrap", 32'(wrap),  32'(i == 0));
    end

    // Jumps: in range, boundary target, out of range
    step(0, 1, 0, 1, 2, 0, 0, 0, 0, "load2");
    check_val("load2_state", 32'(state), 32'd2);
    step(0, 1, 0, 1, 4, 0, 0, 0, 0, "load4");
    check_val("load4_wrap", 32'(wrap), 32'd0);
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, "load0");
    check_val("load0_wrap", 32'(wrap), 32'd0);
    step(0, 0, 0, 1, 7, 0, 0, 0, 0, "load7");
    check_val("load7_state", 32'(state), 32'd0);

    // Table writes: current state, out-of-range address, write with advance
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, "goto3");
    step(0, 0, 0, 0, 0, 1, 3, 8'hA5, 0, "wr_cur");
    check_val("wr_cur_out", 32'(out), 32'hA5);
    step(0, 0, 0, 0, 0, 1, 6, 8'h5A, 0, "wr_oob");
    check_val("wr_oob_out", 32'(out), 32'hA5);
    step(0, 1, 0, 0, 0, 1, 4, 8'h3C, 0, "wr_adv");
    check_val("wr_adv_out", 32'(out), 32'h3C);

    // Dwell hold with an en gap mid-dwell
    step(0, 0, 0, 1, 0, 0, 0, 0, 2, "dw_load");
    for (int i = 0; i < 12; i++) begin
      step(0, !(i == 4 || i == 5), 0, 0, 0, 0, 0, 0, 2, "dwell");
    end

    // Reset mid-sequence with write and jump pending restores the table
    step(0, 0, 0, 1, 3, 1, 1, 8'h77, 0, "pre_rst");
    step(1, 1, 0, 1, 2, 1, 0, 8'h99, 0, "rst_mid");
    check_val("rst_mid_out", 32'(out), 32'd0);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 1, i, 0, 0, 0, 0, "tbl");
      check_val("tbl_restored", 32'(out), 32'(i));
    end

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           ($urandom_range(0, 7) == 0), $urandom_range(0, 7),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 255),
           $urandom_range(0, 3), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/moore_seq_gen.md
MOORE_SEQ_GEN -- requirements
Module: moore_seq_gen

Interface
REQ-001 SHALL have parameter NUM_STATES, default 4, number of sequence states (legal range 2..256).
REQ-002 SHALL have parameter OUT_W, default 8, width of the per-state output pattern.
REQ-003 SHALL have parameter DWELL_W, default 4, width of the dwell configuration.
REQ-004 SHALL derive localparam SW = $clog2(NUM_STATES), the state index width.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  advance enable; low freezes state and dwell count.
REQ-008 dir  in  1  direction: 0 = increment state index, 1 = decrement.
REQ-009 load  in  1  jump request to load_state.
REQ-010 load_state  in  SW  jump target index.
REQ-011 pat_we  in  1  pattern-table write strobe.
REQ-012 pat_addr  in  SW  pattern-table write index.
REQ-013 pat_data  in  OUT_W  pattern-table write data.
REQ-014 dwell_cfg  in  DWELL_W  extra cycles to hold each state.
REQ-015 out  out  OUT_W  Moore output, pattern[state].
REQ-016 state  out  SW  current state index.
REQ-017 wrap  out  1  one-cycle pulse on boundary wrap.

Function
REQ-018 out SHALL depend only on the current state and table contents, never combinationally on any input.
REQ-019 Priority per cycle SHALL be load, then en-advance, then hold.
REQ-020 On load, state SHALL become load_state next cycle, or 0 if load_state >= NUM_STATES, regardless of en.
REQ-021 On advance with dir=0, state SHALL step by +1, with NUM_STATES-1 wrapping to 0.
REQ-022 On advance with dir=1, state SHALL step by -1, with 0 wrapping to NUM_STATES-1.
REQ-023 wrap SHALL be registered and high exactly in the first cycle of the new state after a wrap transition.
REQ-024 wrap SHALL be low after a load, including a load that targets a boundary state.
REQ-025 A pat_we write SHALL update the table at the clock edge; a write to the current state SHALL be visible on out next cycle.
REQ-026 A write with pat_addr >= NUM_STATES SHALL be ignored.
REQ-027 pat_we and load/advance in the same cycle SHALL both take effect; out then shows the new state's updated entry.
REQ-028 A dir change SHALL take effect on the next advance with no extra latency.

Reset
REQ-029 Reset SHALL set state = 0, wrap = 0 and dwell count = 0.
REQ-030 Reset SHALL initialise pattern[i] = i, zero-extended or truncated to OUT_W, so NUM_STATES=2, OUT_W=1 yields a 0/1 toggle.
REQ-031 Reset SHALL override load, en and pat_we when asserted with them, including mid-sequence.
REQ-032 out SHALL equal pattern[0] = 0 in the first cycle after reset.

Configuration
REQ-033 Macro MOORE_SEQ_DWELL_EN defined SHALL select dwell mode:
- an internal DWELL_W counter increments while en = 1;
- advance occurs only when en = 1 and count == dwell_cfg;
- the count clears on every state change and on load;
- dwell_cfg = 0 means advance on every en cycle.
REQ-034 Macro MOORE_SEQ_DWELL_EN undefined SHALL select plain mode:
- dwell_cfg is ignored and no counter is implemented;
- every en = 1 cycle advances the state.

Structure
REQ-035 Package moore_seq_pkg SHALL hold the dir encoding (DIR_UP = 0, DIR_DOWN = 1) and the next-index wrap function.
REQ-036 The dwell logic SHALL be sub-module moore_seq_dwell (counter plus compare, emits adv_ok), instantiated only under MOORE_SEQ_DWELL_EN.

Verification
REQ-037 Reset, then en = 1, dir = 0, NUM_STATES = 4 -> state 0,1,2,3,0; wrap high only in the cycle state returns to 0.
REQ-038 dir = 1 from state 0 -> state 3 with wrap = 1, then 2, 1, 0.
REQ-039 load = 1, load_state = 2, en = 1 -> state = 2 next cycle, wrap = 0; load_state = 7 with NUM_STATES = 5 -> state = 0.
REQ-040 pat_we, pat_addr = current state, pat_data = 8'hA5 -> out = 8'hA5 next cycle; pat_addr = 6 with NUM_STATES = 5 -> no table change.
REQ-041 MOORE_SEQ_DWELL_EN, dwell_cfg = 2, en = 1 -> each state held 3 cycles; en low for 2 cycles mid-dwell extends the hold by 2.
REQ-042 reset asserted in state 3 with pat_we and load both high -> state = 0, out = 0, table restored to pattern[i] = i.
